rom_sequencer: RTL and testbench
================================

Name: rom_sequencer

Overview:
- Producer side of the operand interface feeding the CPU/manual mode mux; it generates cpu_a, cpu_b and cpu_opcode from an internal instruction ROM.
- Fetches each ROM word, issues operands to the ALU path, waits a fixed ALU latency, then captures the result into an accumulator.
- Runs only while mode=1 (ROM mode). Holds its program counter while mode=0 (manual).

Parameters:
- DEPTH, 8, number of ROM words; power of two, at least 2.
- ADDR_W, 3, program counter width; equals log2(DEPTH).
- ALU_LAT, 1, cycles from issue to a valid alu_result; at least 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  1  1 = ROM execution enabled, 0 = manual (sequencer idles).
- restart  in  1  synchronous; sets pc to 0, clears halted and acc.
- alu_result  in  8  ALU output for the last issued operation.
- cpu_a  out  8  operand A to the mode mux.
- cpu_b  out  8  operand B to the mode mux.
- cpu_opcode  out  3  ALU opcode to the mode mux.
- cpu_valid  out  1  one-cycle pulse marking a new issue.
- pc  out  ADDR_W  address of the current instruction.
- acc  out  8  accumulator.
- halted  out  1  high while in HALT.

Behaviour:
- ROM word is 21 bits:
  - [20] HALT
  - [19] A_SRC (0 = IMM_A, 1 = acc)
  - [18:16] OPCODE
  - [15:8] IMM_A
  - [7:0] IMM_B
- ROM is a constant table. Default program:
  - 0: {0,0,3'd0,8'h05,8'h03}
  - 1: {0,1,3'd1,8'h00,8'h02}
  - 2: {0,1,3'd0,8'h00,8'h10}
  - 3 to 7: HALT=1, other fields 0.
- Reset (asynchronous assert, synchronous release): state=IDLE; pc, acc, cpu_a, cpu_b, cpu_opcode = 0; cpu_valid=0; halted=0.
- States: IDLE, FETCH, ISSUE, WAIT, HALT.
- IDLE: if mode=1, go to FETCH next cycle.
- FETCH: register rom[pc]. If HALT=1, go to HALT; otherwise go to ISSUE.
- ISSUE:
  - Drive cpu_a = A_SRC ? acc : IMM_A, cpu_b = IMM_B, cpu_opcode = OPCODE, all registered.
  - cpu_valid=1 for exactly this cycle.
  - Load the wait counter with ALU_LAT, then go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - On the cycle the counter reaches 1: acc <= alu_result, pc <= pc+1 (wraps to 0 after DEPTH-1), go to FETCH.
  - Issue-to-capture latency = ALU_LAT cycles.
- HALT: halted=1; remains until restart or reset. mode has no effect here.
- Output stability: cpu_a, cpu_b and cpu_opcode hold their last issued values outside ISSUE. They never change during WAIT.
- mode falls to 0 in FETCH, ISSUE or WAIT:
  - Return to IDLE at the next edge.
  - The in-flight result is discarded: no acc or pc update.
  - pc is kept, so the same instruction re-executes on resume.
  - cpu_valid is forced to 0.
- restart=1 in any state:
  - Next state is IDLE; pc=0, acc=0, halted=0.
  - cpu_a, cpu_b and cpu_opcode hold their values.
  - restart has priority over mode and all state transitions.
- Simultaneous restart with a WAIT capture: restart wins and no capture occurs.
- Throughput: one instruction per ALU_LAT+2 cycles. Default = 3 cycles per instruction.

Test Plan:
- Reset, then mode=1 with the bench ALU modelling op0=ADD and op1=SUB (ALU_LAT=1):
  - Issues appear as (a,b,op) = (05,03,0), then (08,02,1), then (06,10,0).
  - acc ends at 0x16, pc=3, halted=1.
  - cpu_valid pulses exactly 3 times, 3 cycles apart.
- mode=0 from reset for 20 cycles: cpu_valid never asserts, pc=0, outputs stay 0.
- Drop mode to 0 during WAIT of instruction 1, hold 5 cycles, then raise it:
  - acc stays 0x08 during the pause.
  - Instruction 1 is re-issued with (08,02,1); the final acc is 0x16.
- From HALT, pulse restart for 1 cycle with mode=1: halted falls, pc=0, acc=0, and the program reruns to acc=0x16.
- Assert rst_n low mid-WAIT, asynchronously between clock edges: all outputs clear immediately, with no capture on the next edge.
- ALU_LAT=3 build: each capture occurs 3 cycles after its cpu_valid; acc ends at 0x16; cpu_a, cpu_b and cpu_opcode stay stable through every WAIT.

Source files
------------

// File: rtl/rom_sequencer_if.sv
// -----------------------------------------------------------------------------
// rom_sequencer_if
// Operand interface between the ROM sequencer and the CPU/manual mode mux.
//
// Signals:
//   mode        1 = ROM execution enabled, 0 = manual (sequencer idles)
//   restart     synchronous restart: pc, acc and halted cleared
//   alu_result  ALU output for the last issued operation
//   cpu_a       operand A to the mode mux
//   cpu_b       operand B to the mode mux
//   cpu_opcode  ALU opcode to the mode mux
//   cpu_valid   one-cycle pulse marking a new issue
//   pc          address of the current instruction
//   acc         accumulator
//   halted      high while the sequencer sits in HALT
//
// Modports:
//   master  the sequencer (drives operands and status)
//   slave   the consumer / controller (drives mode, restart, alu_result)
// -----------------------------------------------------------------------------
interface rom_sequencer_if #(
  parameter int ADDR_W = 3
);
  logic              mode;
  logic              restart;
  logic [7:0]        alu_result;
  logic [7:0]        cpu_a;
  logic [7:0]        cpu_b;
  logic [2:0]        cpu_opcode;
  logic              cpu_valid;
  logic [ADDR_W-1:0] pc;
  logic [7:0]        acc;
  logic              halted;

  modport master (
    input  mode,
    input  restart,
    input  alu_result,
    output cpu_a,
    output cpu_b,
    output cpu_opcode,
    output cpu_valid,
    output pc,
    output acc,
    output halted
  );

  modport slave (
    output mode,
    output restart,
    output alu_result,
    input  cpu_a,
    input  cpu_b,
    input  cpu_opcode,
    input  cpu_valid,
    input  pc,
    input  acc,
    input  halted
  );
endinterface

// File: rtl/rom_sequencer.sv
// -----------------------------------------------------------------------------
// rom_sequencer
// Producer side of the operand interface feeding the CPU/manual mode mux.
// Walks a constant instruction ROM: fetches a word, issues operands to the
// ALU path, waits ALU_LAT cycles, then captures alu_result into the
// accumulator and advances the program counter. Runs only while mode=1.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (synchronous release upstream)
//   bus    rom_sequencer_if.master: mode, restart, alu_result in;
//          cpu_a, cpu_b, cpu_opcode, cpu_valid, pc, acc, halted out
//
// ROM word layout (21 bits):
//   [20] HALT  [19] A_SRC (0 = IMM_A, 1 = acc)  [18:16] OPCODE
//   [15:8] IMM_A  [7:0] IMM_B
//
// Timing: operands and cpu_valid are registered as the FSM leaves ISSUE, so
// they become visible in the first WAIT cycle; the capture edge follows that
// edge by exactly ALU_LAT cycles. With ALU_LAT=1 an instruction takes
// FETCH + ISSUE + WAIT = 3 cycles.
// -----------------------------------------------------------------------------
module rom_sequencer #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 3,
  parameter int ALU_LAT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rom_sequencer_if.master        bus
);

  localparam int CNT_W = $clog2(ALU_LAT + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_WAIT  = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  // Constant program table; every unlisted address is a HALT word.
  function automatic logic [20:0] rom_word(input logic [ADDR_W-1:0] addr);
    logic [20:0] w;
    case (addr)
      ADDR_W'(0): w = {1'b0, 1'b0, 3'd0, 8'h05, 8'h03};
      ADDR_W'(1): w = {1'b0, 1'b1, 3'd1, 8'h00, 8'h02};
      ADDR_W'(2): w = {1'b0, 1'b1, 3'd0, 8'h00, 8'h10};
      default:    w = {1'b1, 20'h0_0000};
    endcase
    return w;
  endfunction

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [7:0]        r_acc;
  logic [19:0]       r_word;
  logic [CNT_W-1:0]  r_cnt;
  logic [7:0]        r_cpu_a;
  logic [7:0]        r_cpu_b;
  logic [2:0]        r_cpu_op;
  logic              r_cpu_valid;
  logic              r_halted;

  logic [20:0]       w_rom_word;
  logic [ADDR_W-1:0] w_pc_inc;
  logic              w_do_fetch;
  logic              w_do_halt;
  logic              w_do_issue;
  logic              w_do_count;
  logic              w_do_capture;

  assign w_rom_word = rom_word(r_pc);
  assign w_pc_inc   = (r_pc == ADDR_W'(DEPTH - 1)) ? '0 : r_pc + ADDR_W'(1);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic and per-cycle action strobes. restart overrides
  // everything; mode=0 aborts any in-flight instruction back to IDLE.
  always_comb begin
    w_state_next = r_state;
    w_do_fetch   = 1'b0;
    w_do_halt    = 1'b0;
    w_do_issue   = 1'b0;
    w_do_count   = 1'b0;
    w_do_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.mode) begin
          w_state_next = ST_FETCH;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (!bus.mode) begin
          w_state_next = ST_IDLE;
        end else if (w_rom_word[20]) begin
          w_state_next = ST_HALT;
          w_do_halt    = 1'b1;
        end else begin
          w_state_next = ST_ISSUE;
          w_do_fetch   = 1'b1;
        end
      end
      ST_ISSUE: begin
        if (!bus.mode) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_WAIT;
          w_do_issue   = 1'b1;
        end
      end
      ST_WAIT: begin
        if (!bus.mode) begin
          w_state_next = ST_IDLE;
        end else if (r_cnt == CNT_W'(1)) begin
          w_state_next = ST_FETCH;
          w_do_capture = 1'b1;
        end else begin
          w_state_next = ST_WAIT;
          w_do_count   = 1'b1;
        end
      end
      ST_HALT: begin
        w_state_next = ST_HALT;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
    if (bus.restart) begin
      w_state_next = ST_IDLE;
      w_do_fetch   = 1'b0;
      w_do_halt    = 1'b0;
      w_do_issue   = 1'b0;
      w_do_count   = 1'b0;
      w_do_capture = 1'b0;
    end else begin
      w_state_next = w_state_next;
    end
  end

  // Program counter, accumulator and halted flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc     <= '0;
      r_acc    <= 8'h00;
      r_halted <= 1'b0;
    end else if (bus.restart) begin
      r_pc     <= '0;
      r_acc    <= 8'h00;
      r_halted <= 1'b0;
    end else begin
      if (w_do_capture) begin
        r_acc <= bus.alu_result;
        r_pc  <= w_pc_inc;
      end
      if (w_do_halt) begin
        r_halted <= 1'b1;
      end
    end
  end

  // Fetched instruction word (HALT bit is consumed directly from the ROM).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= 20'h0_0000;
    end else if (w_do_fetch) begin
      r_word <= w_rom_word[19:0];
    end
  end

  // Issued operands: updated only on issue so they hold through WAIT and
  // across restart; cpu_valid is a single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_a     <= 8'h00;
      r_cpu_b     <= 8'h00;
      r_cpu_op    <= 3'd0;
      r_cpu_valid <= 1'b0;
    end else begin
      r_cpu_valid <= w_do_issue;
      if (w_do_issue) begin
        r_cpu_a  <= r_word[19] ? r_acc : r_word[15:8];
        r_cpu_b  <= r_word[7:0];
        r_cpu_op <= r_word[18:16];
      end
    end
  end

  // ALU latency counter: loaded on issue, counts down to 1 in WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_do_issue) begin
      r_cnt <= CNT_W'(ALU_LAT);
    end else if (w_do_count) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign bus.cpu_a      = r_cpu_a;
  assign bus.cpu_b      = r_cpu_b;
  assign bus.cpu_opcode = r_cpu_op;
  assign bus.cpu_valid  = r_cpu_valid;
  assign bus.pc         = r_pc;
  assign bus.acc        = r_acc;
  assign bus.halted     = r_halted;

endmodule

// File: tb/tb_rom_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rom_sequencer
// Self-checking bench for rom_sequencer. Two instances: ALU_LAT=1 and
// ALU_LAT=3, each with a combinational ADD/SUB ALU model. Expected issues
// are queued when a program run is started and popped as cpu_valid pulses.
// -----------------------------------------------------------------------------
module tb_rom_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [18:0] q1[$];
  logic [18:0] q3[$];
  int   vcount1 = 0;
  int   vcount3 = 0;
  int   ncap3   = 0;
  int   last1   = 0;
  bit   have_last1 = 1'b0;
  bit   spacing_en = 1'b0;
  bit   pend3 = 1'b0;
  int   vcyc3 = 0;
  logic [18:0] held3 = '0;
  logic [2:0]  prev_pc3 = '0;

  rom_sequencer_if #(.ADDR_W(3)) if1 ();
  rom_sequencer_if #(.ADDR_W(3)) if3 ();

  rom_sequencer #(.DEPTH(8), .ADDR_W(3), .ALU_LAT(1)) u_dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  rom_sequencer #(.DEPTH(8), .ADDR_W(3), .ALU_LAT(3)) u_dut3 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if3)
  );

  function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                           input logic [2:0] op);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      default: return 8'h00;
    endcase
  endfunction

  assign if1.alu_result = alu_model(if1.cpu_a, if1.cpu_b, if1.cpu_opcode);
  assign if3.alu_result = alu_model(if3.cpu_a, if3.cpu_b, if3.cpu_opcode);

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Scoreboard / spacing monitor for the ALU_LAT=1 instance.
  always @(negedge clk) begin
    if (!spacing_en) have_last1 = 1'b0;
    if (rst_n && if1.cpu_valid) begin
      vcount1++;
      check_eq("issue1_expected", (q1.size() != 0), 1);
      if (q1.size() != 0)
        check_eq("issue1_abop", {if1.cpu_a, if1.cpu_b, if1.cpu_opcode}, q1.pop_front());
      if (spacing_en && have_last1) check_eq("issue1_spacing", cyc - last1, 3);
      last1 = cyc;
      have_last1 = 1'b1;
    end
  end

  // Scoreboard, capture latency and operand stability for ALU_LAT=3.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if3.cpu_valid) begin
        vcount3++;
        check_eq("issue3_expected", (q3.size() != 0), 1);
        if (q3.size() != 0)
          check_eq("issue3_abop", {if3.cpu_a, if3.cpu_b, if3.cpu_opcode}, q3.pop_front());
        pend3 = 1'b1;
        vcyc3 = cyc;
        held3 = {if3.cpu_a, if3.cpu_b, if3.cpu_opcode};
      end else if (pend3) begin
        check_eq("wait3_stable", {if3.cpu_a, if3.cpu_b, if3.cpu_opcode}, held3);
      end
      if (pend3 && (if3.pc != prev_pc3)) begin
        check_eq("capture3_latency", cyc - vcyc3, 3);
        pend3 = 1'b0;
        ncap3++;
      end
      prev_pc3 = if3.pc;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid1(input int target, input int budget, input string tag);
    int n = 0;
    while (vcount1 < target && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, (vcount1 >= target), 1);
  endtask

  task automatic wait_halt(input bit sel, input int budget, input string tag);
    int n = 0;
    while (!(sel ? if3.halted : if1.halted) && n < budget) begin
      tick();
      n++;
    end
    check_eq(tag, (sel ? if3.halted : if1.halted), 1);
  endtask

  task automatic push_prog1();
    q1.push_back({8'h05, 8'h03, 3'd0});
    q1.push_back({8'h08, 8'h02, 3'd1});
    q1.push_back({8'h06, 8'h10, 3'd0});
  endtask

  task automatic do_restart1();
    if1.restart = 1'b1;
    tick();
    if1.restart = 1'b0;
  endtask

  initial begin
    int base;
    if1.mode = 1'b0; if1.restart = 1'b0;
    if3.mode = 1'b0; if3.restart = 1'b0;

    // Reset state.
    repeat (3) tick();
    check_eq("rst_abop", {if1.cpu_a, if1.cpu_b, if1.cpu_opcode}, 19'd0);
    check_eq("rst_status", {if1.cpu_valid, if1.halted, if1.pc, if1.acc}, 13'd0);
    rst_n = 1'b1;

    // Manual mode: nothing issues for 20 cycles.
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("manual_valid", if1.cpu_valid, 0);
    end
    check_eq("manual_pc", if1.pc, 0);
    check_eq("manual_abop", {if1.cpu_a, if1.cpu_b, if1.cpu_opcode}, 19'd0);
    check_eq("manual_count", vcount1, 0);

    // Full program run.
    push_prog1();
    spacing_en = 1'b1;
    if1.mode = 1'b1;
    wait_halt(1'b0, 60, "run_halt_timeout");
    check_eq("run_acc", if1.acc, 8'h16);
    check_eq("run_pc", if1.pc, 3);
    check_eq("run_count", vcount1, 3);
    repeat (4) tick();
    check_eq("halt_hold", {if1.halted, if1.pc}, {1'b1, 3'd3});

    // Restart from HALT with mode=1, program reruns.
    push_prog1();
    have_last1 = 1'b0;
    do_restart1();
    check_eq("restart_status", {if1.halted, if1.pc, if1.acc}, 12'd0);
    check_eq("restart_abop_hold", {if1.cpu_a, if1.cpu_b, if1.cpu_opcode}, {8'h06, 8'h10, 3'd0});
    wait_halt(1'b0, 60, "rerun_halt_timeout");
    check_eq("rerun_acc", if1.acc, 8'h16);
    spacing_en = 1'b0;

    // Drop mode during WAIT of instruction 1, pause, resume.
    if1.mode = 1'b0;
    do_restart1();
    base = vcount1;
    q1.push_back({8'h05, 8'h03, 3'd0});
    q1.push_back({8'h08, 8'h02, 3'd1});
    q1.push_back({8'h08, 8'h02, 3'd1});
    q1.push_back({8'h06, 8'h10, 3'd0});
    if1.mode = 1'b1;
    wait_valid1(base + 2, 30, "pause_valid_timeout");
    if1.mode = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("pause_acc", if1.acc, 8'h08);
      check_eq("pause_pc", if1.pc, 1);
    end
    if1.mode = 1'b1;
    wait_halt(1'b0, 60, "resume_halt_timeout");
    check_eq("resume_acc", if1.acc, 8'h16);
    check_eq("resume_count", vcount1 - base, 4);

    // Asynchronous reset mid-WAIT.
    if1.mode = 1'b0;
    do_restart1();
    base = vcount1;
    q1.push_back({8'h05, 8'h03, 3'd0});
    if1.mode = 1'b1;
    wait_valid1(base + 1, 30, "arst_valid_timeout");
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_abop", {if1.cpu_a, if1.cpu_b, if1.cpu_opcode}, 19'd0);
    check_eq("arst_status", {if1.cpu_valid, if1.halted, if1.pc, if1.acc}, 13'd0);
    @(posedge clk);
    #1;
    check_eq("arst_no_capture", {if1.pc, if1.acc}, 11'd0);
    if1.mode = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // ALU_LAT=3 instance runs its program.
    q3.push_back({8'h05, 8'h03, 3'd0});
    q3.push_back({8'h08, 8'h02, 3'd1});
    q3.push_back({8'h06, 8'h10, 3'd0});
    if3.mode = 1'b1;
    wait_halt(1'b1, 100, "lat3_halt_timeout");
    check_eq("lat3_acc", if3.acc, 8'h16);
    check_eq("lat3_pc", if3.pc, 3);
    check_eq("lat3_captures", ncap3, 3);
    check_eq("lat3_count", vcount3, 3);

    check_eq("q1_drained", q1.size(), 0);
    check_eq("q3_drained", q3.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
